// File: rtl/divider_lock_controller.sv
// Closed-loop calibration of the psi clock divider.
// Steps the divisor until psi high time sits within tolerance.
module divider_lock_controller #(
    parameter int DIV_W     = 4,
    parameter int CNT_W     = 8,
    parameter int LOCK_CNT  = 3,
    parameter int MAX_TRIES = 16,
    parameter int WDT_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             psi,
    input  logic [CNT_W-1:0] setPeriod,
    input  logic [3:0]       tolerance,
    input  logic [DIV_W-1:0] initDiv,
    output logic [DIV_W-1:0] div_out,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic             meas_valid,
    output logic [CNT_W-1:0] last_duration
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_RISE,
        S_MEASURE,
        S_EVAL,
        S_SETTLE,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] ld_nxt;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] dur_nxt;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_nxt;
    logic [TRY_W-1:0] tries_inc;
    logic [3:0]       good;
    logic [3:0]       good_nxt;
    logic [3:0]       good_inc;
    logic [WDT_W-1:0] wdt;
    logic [WDT_W-1:0] wdt_nxt;
    logic             psi_d;
    logic             rise;
    logic             fall;
    logic             counting;
    logic             wdt_expired;
    logic [CNT_W:0]   diff;
    logic             in_tol;
    logic             step_up;
    logic             at_lim;

    assign rise        = psi & ~psi_d;
    assign fall        = ~psi & psi_d;
    assign counting    = (state == S_WAIT_RISE) ||
                         (state == S_MEASURE) ||
                         (state == S_SETTLE);
    assign wdt_expired = counting && (wdt == '1) && !(rise || fall);
    assign tries_inc   = tries + 1'b1;
    assign good_inc    = good + 1'b1;
    assign step_up     = last_duration < setPeriod;
    assign at_lim      = step_up ? (div_out == '1) : (div_out == '0);
    assign in_tol      = diff <= {{(CNT_W - 3){1'b0}}, tolerance};

    assign busy   = (state == S_LOAD) || (state == S_EVAL) || counting;
    assign locked = (state == S_LOCKED);
    assign fail   = (state == S_FAIL);

    // absolute error between the last measurement and the live target
    always_comb begin
        diff = '0;
        if (last_duration >= setPeriod)
            diff = {1'b0, last_duration} - {1'b0, setPeriod};
        else
            diff = {1'b0, setPeriod} - {1'b0, last_duration};
    end

    // next-state, datapath updates and the measurement strobe
    always_comb begin
        state_nxt  = state;
        div_nxt    = div_out;
        ld_nxt     = last_duration;
        dur_nxt    = dur;
        tries_nxt  = tries;
        good_nxt   = good;
        meas_valid = 1'b0;
        if (rise || fall)
            wdt_nxt = '0;
        else if (counting)
            wdt_nxt = wdt + 1'b1;
        else
            wdt_nxt = wdt;

        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                div_nxt   = initDiv;
                tries_nxt = '0;
                good_nxt  = '0;
                wdt_nxt   = '0;
                state_nxt = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (wdt_expired) begin
                    state_nxt = S_FAIL;
                end else if (rise) begin
                    dur_nxt   = 1;
                    state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (wdt_expired) begin
                    state_nxt = S_FAIL;
                end else if (fall) begin
                    ld_nxt     = dur;
                    meas_valid = 1'b1;
                    state_nxt  = S_EVAL;
                end else if (psi && dur != '1) begin
                    dur_nxt = dur + 1'b1;
                end
            end
            S_EVAL: begin
                if (in_tol) begin
                    good_nxt = good_inc;
                    if (good_inc == 4'(LOCK_CNT))
                        state_nxt = S_LOCKED;
                    else
                        state_nxt = S_SETTLE;
                end else begin
                    good_nxt  = '0;
                    tries_nxt = tries_inc;
                    if (!at_lim)
                        div_nxt = step_up ? div_out + 1'b1
                                          : div_out - 1'b1;
                    if (at_lim || tries_inc == TRY_W'(MAX_TRIES))
                        state_nxt = S_FAIL;
                    else
                        state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (wdt_expired)
                    state_nxt = S_FAIL;
                else if (fall)
                    state_nxt = S_WAIT_RISE;
            end
            S_LOCKED, S_FAIL: begin
                if (start)
                    state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (abort) begin
            state_nxt  = S_IDLE;
            div_nxt    = div_out;
            ld_nxt     = last_duration;
            dur_nxt    = dur;
            good_nxt   = '0;
            tries_nxt  = '0;
            wdt_nxt    = '0;
            meas_valid = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            div_out       <= '0;
            last_duration <= '0;
            dur           <= '0;
            tries         <= '0;
            good          <= '0;
            wdt           <= '0;
            psi_d         <= 1'b0;
        end else begin
            state         <= state_nxt;
            div_out       <= div_nxt;
            last_duration <= ld_nxt;
            dur           <= dur_nxt;
            tries         <= tries_nxt;
            good          <= good_nxt;
            wdt           <= wdt_nxt;
            psi_d         <= psi;
        end
    end

endmodule

// File: doc/divider_lock_controller.md
Name: divider_lock_controller

Overview:
Sequences the programmable clock divider that generates the psi pulse train until psi's high time matches a target length. The block runs a closed calibration loop: load an initial divisor, measure one psi high pulse in clk cycles, compare it against the target, step the divisor, discard one pulse so the change settles, and repeat. It declares lock after LOCK_CNT consecutive in-tolerance measurements, and declares failure on divisor limit, try exhaustion or missing psi activity. It sits between the lab control/switch logic and the divider.

Parameters:
DIV_W, 4, divisor width
CNT_W, 8, duration counter and setPeriod width
LOCK_CNT, 3, consecutive in-tolerance measurements required for lock (1..15)
MAX_TRIES, 16, out-of-tolerance corrections allowed before fail
WDT_W, 12, watchdog width; timeout after 2^WDT_W-1 cycles without a psi edge

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin calibration
abort  in  1  synchronous; return to IDLE, divisor retained
psi  in  1  divided pulse train, already synchronous to clk
setPeriod  in  CNT_W  target psi high time in clk cycles
tolerance  in  4  allowed absolute error in cycles
initDiv  in  DIV_W  starting divisor, sampled in LOAD
div_out  out  DIV_W  divisor driven to the divider
busy  out  1  high in LOAD/WAIT_RISE/MEASURE/EVAL/SETTLE
locked  out  1  high in LOCKED
fail  out  1  high in FAIL
meas_valid  out  1  one-cycle pulse when last_duration updates
last_duration  out  CNT_W  most recent measured high time

Behaviour:
- Reset: state=IDLE; div_out=0, last_duration=0, duration=0, tries=0, good=0, wdt=0, psi_d=0; all flag outputs 0.
- psi_d registers psi every cycle. rise = psi & ~psi_d; fall = ~psi & psi_d.
- IDLE: on start go to LOAD. abort in IDLE has no effect.
- LOAD (1 cycle): div_out<=initDiv, tries<=0, good<=0, wdt<=0; go to WAIT_RISE.
- WAIT_RISE: on rise, duration<=1 and go to MEASURE. If psi is already high on entry, wait for the next rise.
- MEASURE: while psi=1, duration<=duration+1, saturating at 2^CNT_W-1. On fall, last_duration<=duration, meas_valid=1 that cycle, go to EVAL.
- EVAL (1 cycle): in tolerance when |last_duration-setPeriod|<=tolerance, computed at CNT_W+1 bits unsigned magnitude.
  - In tolerance: good<=good+1. If good+1==LOCK_CNT go to LOCKED, else go to SETTLE.
  - Otherwise: good<=0, tries<=tries+1.
    - If last_duration<setPeriod: div_out+1. If div_out is already max, go to FAIL with the divisor unchanged.
    - Else: div_out-1. If div_out is already 0, go to FAIL.
    - If tries+1==MAX_TRIES, go to FAIL after applying the step. Otherwise go to SETTLE.
- SETTLE: wait for the next fall (discards one pulse), then go to WAIT_RISE.
- Lock timing: locked rises the cycle after EVAL, i.e. 2 clk after the fall edge of the final pulse is sampled.
- LOCKED / FAIL: busy=0, div_out held. start goes to LOAD (full restart).
- Watchdog: wdt clears on any rise/fall and counts in WAIT_RISE/MEASURE/SETTLE. At all-ones, go to FAIL.
- start while busy is ignored.
- abort takes priority over every transition: go to IDLE next cycle, keep div_out and last_duration, clear good/tries/wdt.
- rst mid-operation returns immediately to reset values.
- setPeriod/tolerance are sampled live in EVAL. Changing them between measurements is legal.

Test Plan:
- Lock: initDiv=5, setPeriod=10, tolerance=1, psi high 10 clk ×5 pulses -> locked=1 two clk after the 3rd measured fall; div_out stays 5; last_duration=10.
- Step up: initDiv=3, measured highs of 6 then settled highs of 10, setPeriod=10, tol=0 -> div_out 3→4 after the first EVAL; the next pulse is discarded; lock after 3 subsequent 10-cycle pulses.
- Boundaries: initDiv=0 with duration>setPeriod -> fail=1, div_out=0. initDiv=15 with duration<setPeriod -> fail=1, div_out=15.
- Exhaustion: tolerance=0, durations alternate 9/11 around setPeriod=10 -> fail after the 16th correction; busy=0.
- Watchdog/saturation: psi held high 300 clk -> duration saturates at 255. psi stuck low after LOAD -> fail after 4095 clk.
- Abort/reset/start-while-busy:
  - abort mid-MEASURE -> IDLE next clk, div_out kept.
  - rst mid-SETTLE -> all outputs 0.
  - start pulsed in MEASURE -> no restart; tries unchanged.
